oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sits directly downstream of the CPU core's memory bus and upstream of the system bus decoder (RAM, PPU registers, cartridge).
- Transparently passes CPU bus cycles through.
- On a CPU write to the OAM DMA register ($4014), halts the CPU and copies 256 bytes from page {value,8'h00} to the PPU OAM data port ($2004).
- Provides the NES sprite-DMA function the CPU core itself lacks.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- ODD_ALIGN, 1, when 1, insert an extra alignment cycle if DMA starts on an odd cycle.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- cpu_addr  in  16  CPU memory address
- cpu_data_out  in  8  CPU write data
- cpu_write_en  in  1  CPU write strobe
- cpu_read_en  in  1  CPU read strobe
- cpu_halt  out  1  CPU must freeze all state while high
- bus_addr  out  16  system bus address
- bus_data_out  out  8  system bus write data
- bus_write_en  out  1  system bus write strobe
- bus_read_en  out  1  system bus read strobe
- bus_data_in  in  8  system bus read data, valid the cycle after bus_read_en
- dma_active  out  1  high whenever DMA owns the bus (same as cpu_halt)

Behaviour:

Clock and reset:
- One clock, clk. Reset is synchronous and active-low: rst low at a rising edge resets the block.
- Reset state: IDLE, cpu_halt=0, dma_active=0, page=0, idx=0, parity=0.
- Reset mid-DMA aborts immediately. No further bus writes occur; bus returns to passthrough the cycle after reset.

Parity:
- 1-bit counter toggling every clock from reset.

IDLE (passthrough):
- bus_addr/bus_data_out/bus_write_en/bus_read_en equal the CPU signals combinationally.
- When cpu_write_en=1 and cpu_addr=DMA_REG_ADDR, the write still passes to the bus, page latches cpu_data_out, and the next state is HALT.

States (cpu_halt=1 in all of them):
- HALT: 1 dummy cycle, all bus strobes 0. Next state is ALIGN if ODD_ALIGN=1 and parity=1 in this cycle, else READ.
- ALIGN: 1 dummy cycle, strobes 0, then READ.
- READ: bus_addr={page,idx}, bus_read_en=1, bus_write_en=0. Next state is WRITE.
- WRITE: bus_addr=OAM_DATA_ADDR, bus_data_out=bus_data_in (combinational forward), bus_write_en=1, bus_read_en=0.
  - If idx=8'hFF: go to IDLE, idx→0.
  - Else: idx increments, go to READ.

Outputs and timing:
- While halted, CPU strobes are ignored and never reach the bus.
- cpu_halt and dma_active are decoded from state (state≠IDLE). Both rise the cycle after the trigger write and fall in the cycle after the last WRITE.
- Total halted cycles: 513 (no align) or 514 (align).

Boundaries:
- idx is 8-bit and never carries into page. Page 8'hFF reads $FF00–$FFFF.
- A trigger write while not IDLE cannot occur (CPU is halted). It is ignored if it does.
- Page 8'h20 (reading PPU space) is permitted; no special handling.

Test Plan:
1. Passthrough: CPU read $0010, then write $0300←8'h5A with no DMA → bus mirrors same cycle; cpu_halt stays 0.
2. Even-parity trigger: write $4014←8'h02 with parity 0 in the HALT cycle; RAM $0200+i=i^8'hA5 → 256 writes to $2004 with data i^8'hA5 in order; cpu_halt high exactly 513 cycles.
3. Odd-parity trigger: same stimulus shifted one cycle → ALIGN inserted; cpu_halt high exactly 514 cycles; data identical.
4. CPU strobes during DMA: hold cpu_write_en=1, cpu_addr=$0000 throughout → no bus write to $0000; only $2004 writes appear.
5. Page wrap: write $4014←8'hFF → reads $FF00..$FFFF; no read from $0000 after $FFFF.
6. Reset mid-op: assert rst low after the 100th WRITE → next cycle cpu_halt=0, idx=0, IDLE; OAM received exactly 100 bytes; a new trigger restarts from idx 0.

Source files
------------

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and system-bus-side signals of the OAM DMA controller.
// The controller takes the slave view; the CPU/bus environment takes the master view.
interface oam_dma_ctrl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_write_en;
    logic        cpu_read_en;
    logic        cpu_halt;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_write_en;
    logic        bus_read_en;
    logic [7:0]  bus_data_in;
    logic        dma_active;

    modport slave (
        input  cpu_addr, cpu_data_out, cpu_write_en, cpu_read_en, bus_data_in,
        output cpu_halt, dma_active, bus_addr, bus_data_out, bus_write_en, bus_read_en
    );

    modport master (
        output cpu_addr, cpu_data_out, cpu_write_en, cpu_read_en, bus_data_in,
        input  cpu_halt, dma_active, bus_addr, bus_data_out, bus_write_en, bus_read_en
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// NES sprite DMA: passes CPU cycles to the system bus, and on a write to the
// DMA register halts the CPU and copies one 256-byte page to the OAM data port.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter bit          ODD_ALIGN     = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    oam_dma_ctrl_if.slave dma
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t     state;
    logic [7:0] page;
    logic [7:0] idx;
    logic       parity;
    logic       halt_q;

    wire trigger = dma.cpu_write_en && (dma.cpu_addr == DMA_REG_ADDR);

    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            parity <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            parity <= ~parity;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        page   <= dma.cpu_data_out;
                        state  <= S_HALT;
                        halt_q <= 1'b1;
                    end
                end
                // A DMA starting on an odd cycle spends one extra cycle to align reads.
                S_HALT:  state <= (ODD_ALIGN && parity) ? S_ALIGN : S_READ;
                S_ALIGN: state <= S_READ;
                S_READ:  state <= S_WRITE;
                S_WRITE: begin
                    if (idx == 8'hFF) begin
                        idx    <= 8'h00;
                        state  <= S_IDLE;
                        halt_q <= 1'b0;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= S_READ;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    halt_q <= 1'b0;
                end
            endcase
        end
    end

    assign dma.cpu_halt   = halt_q;
    assign dma.dma_active = halt_q;

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        dma.bus_addr     = 16'h0000;
        dma.bus_data_out = 8'h00;
        dma.bus_write_en = 1'b0;
        dma.bus_read_en  = 1'b0;
        case (state)
            S_IDLE: begin
                dma.bus_addr     = dma.cpu_addr;
                dma.bus_data_out = dma.cpu_data_out;
                dma.bus_write_en = dma.cpu_write_en;
                dma.bus_read_en  = dma.cpu_read_en;
            end
            S_READ: begin
                dma.bus_addr    = {page, idx};
                dma.bus_read_en = 1'b1;
            end
            // Read data arrives the cycle after the read and goes straight to OAM.
            S_WRITE: begin
                dma.bus_addr     = OAM_DATA_ADDR;
                dma.bus_data_out = dma.bus_data_in;
                dma.bus_write_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl: a byte-array bus model plus a transfer-level
// reference (expected page contents, halt length from start-cycle parity).
module tb_oam_dma_ctrl;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;

    logic [7:0] mem [0:65535];

    oam_dma_ctrl_if dif ();

    oam_dma_ctrl #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_DATA_ADDR(16'h2004),
        .ODD_ALIGN    (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dma(dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since the last reset edge; its LSB is the expected DMA parity.
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Synchronous-read memory: data is valid the cycle after bus_read_en.
    always @(posedge clk) begin
        if (dif.bus_read_en) dif.bus_data_in <= mem[dif.bus_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cpu_idle();
        dif.cpu_addr     = 16'h0000;
        dif.cpu_data_out = 8'h00;
        dif.cpu_write_en = 1'b0;
        dif.cpu_read_en  = 1'b0;
    endtask

    // One ordinary CPU cycle; the bus must mirror it and the CPU must not halt.
    task automatic pass_cycle(input logic [15:0] a, input logic [7:0] d, input bit we, input bit re);
        dif.cpu_addr     = a;
        dif.cpu_data_out = d;
        dif.cpu_write_en = we;
        dif.cpu_read_en  = re;
        @(negedge clk);
        check("passthrough",
              {dif.bus_addr, dif.bus_data_out, dif.bus_write_en, dif.bus_read_en, dif.cpu_halt},
              {a, d, we, re, 1'b0});
        @(posedge clk); #1;
        cpu_idle();
    endtask

    // Trigger a DMA from 'page' so that the halt cycle lands on the requested parity.
    // abort_after > 0 pulls reset low right after that many OAM writes.
    task automatic run_dma(input logic [7:0] page, input bit want_align, input bit noise,
                           input int abort_after);
        bit          exp_align;
        int          halt_n, n_rd, n_wr, stray, act_bad;
        logic [15:0] exp_rd;
        logic [15:0] src;
        halt_n = 0; n_rd = 0; n_wr = 0; stray = 0; act_bad = 0;

        if ((((cyc + 1) % 2) == 1) != want_align) begin
            cpu_idle();
            @(posedge clk); #1;
        end
        exp_align = (((cyc + 1) % 2) == 1);

        dif.cpu_addr     = 16'h4014;
        dif.cpu_data_out = page;
        dif.cpu_write_en = 1'b1;
        dif.cpu_read_en  = 1'b0;
        @(negedge clk);
        check("trigger_pass",
              {dif.bus_addr, dif.bus_data_out, dif.bus_write_en, dif.bus_read_en, dif.cpu_halt},
              {16'h4014, page, 1'b1, 1'b0, 1'b0});

        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            if (abort_after > 0 && n_wr == abort_after && rst) begin
                rst = 1'b0;
                cpu_idle();
            end else if (noise && rst) begin
                dif.cpu_addr     = 16'h0000;
                dif.cpu_data_out = 8'($urandom);
                dif.cpu_write_en = 1'b1;
                dif.cpu_read_en  = 1'($urandom);
            end else begin
                cpu_idle();
            end
            @(negedge clk);
            if (!dif.cpu_halt) break;
            halt_n++;
            if (dif.dma_active !== dif.cpu_halt) act_bad++;
            if (dif.bus_write_en && dif.bus_read_en) stray++;
            if (dif.bus_write_en) begin
                if (dif.bus_addr !== 16'h2004) stray++;
                else begin
                    src = {page, 8'(n_wr)};
                    check("oam_data", 32'(dif.bus_data_out), 32'(mem[src]));
                    n_wr++;
                end
            end
            if (dif.bus_read_en) begin
                exp_rd = {page, 8'(n_rd)};
                check("read_addr", 32'(dif.bus_addr), 32'(exp_rd));
                n_rd++;
            end
        end

        check("post_passthrough",
              {dif.bus_addr, dif.bus_write_en, dif.bus_read_en, dif.dma_active},
              {dif.cpu_addr, dif.cpu_write_en, dif.cpu_read_en, 1'b0});
        check("stray_bus_cycles", stray, 0);
        check("active_eq_halt", act_bad, 0);
        if (abort_after > 0) begin
            // HALT, optional ALIGN, N read/write pairs, then the read during reset.
            check("abort_halt_cycles", halt_n, 32'(2 * abort_after + 2 + int'(exp_align)));
            check("abort_oam_count", n_wr, abort_after);
            @(posedge clk); #1;
            rst = 1'b1;
        end else begin
            check("halt_cycles", halt_n, 32'(513 + int'(exp_align)));
            check("oam_count", n_wr, 256);
            check("read_count", n_rd, 256);
            @(posedge clk); #1;
        end
        cpu_idle();
    endtask

    initial begin
        logic [15:0] ra;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        dif.bus_data_in = 8'h00;
        cpu_idle();
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_state", {dif.cpu_halt, dif.dma_active}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;

        pass_cycle(16'h0010, 8'h00, 1'b0, 1'b1);
        pass_cycle(16'h0300, 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            if (ra == 16'h4014) ra = 16'h4015;
            pass_cycle(ra, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        run_dma(8'h02, 1'b0, 1'b0, 0);
        run_dma(8'h02, 1'b1, 1'b0, 0);
        run_dma(8'($urandom), 1'($urandom), 1'b1, 0);
        run_dma(8'hFF, 1'($urandom), 1'b0, 0);
        pass_cycle(16'h0000, 8'h00, 1'b0, 1'b1);
        run_dma(8'($urandom), 1'($urandom), 1'b1, 100);
        run_dma(8'($urandom), 1'($urandom), 1'b0, 0);
        for (int i = 0; i < 2; i++)
            run_dma(8'($urandom), 1'($urandom), 1'($urandom), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
